// File: rtl/decode_stage.sv
// Decode stage: F/D holding register, three-state issue FSM for one- and
// two-word instructions, load-use stall, flush, and an NREG x W register file
// with write-through, feeding a registered D/E pipeline register.
module decode_stage #(
  parameter int              W      = 16,
  parameter int              NREG   = 8,
  parameter int              OPW    = 6,
  parameter logic [OPW-1:0]  IMM_OP = 6'b011001,
  localparam int             RA     = $clog2(NREG),
  localparam int             SHW    = W - OPW - 2*RA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      instr_in,
  input  logic              instr_valid,
  output logic              fd_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [RA-1:0]     wb_addr,
  input  logic [W-1:0]      wb_data,
  input  logic              ex_memread,
  input  logic [RA-1:0]     ex_dst,
  output logic              de_valid,
  output logic [OPW-1:0]    de_opcode,
  output logic [RA-1:0]     de_src,
  output logic [RA-1:0]     de_dst,
  output logic [SHW-1:0]    de_sham,
  output logic [W-1:0]      de_rsrc,
  output logic [W-1:0]      de_rdst,
  output logic [W-1:0]      de_imm
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_IMM = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_n_s;
  logic [W-1:0]    fd_instr_r;
  // An immediate that arrives on the HOLD->WAIT_IMM edge is parked here so
  // the IMM_OP pair can issue on the following edge without losing the word.
  logic [W-1:0]    imm_r;
  logic            imm_pend_r;
  logic [W-1:0]    regs_r [NREG];

  logic [OPW-1:0]  fd_opcode_s;
  logic [RA-1:0]   fd_src_s;
  logic [RA-1:0]   fd_dst_s;
  logic [SHW-1:0]  fd_sham_s;
  logic [W-1:0]    rsrc_s;
  logic [W-1:0]    rdst_s;
  logic            stall_s;
  logic            accept_s;
  logic            fd_load_s;
  logic            imm_cap_s;
  logic            pend_clr_s;
  logic            issue_s;
  logic [W-1:0]    issue_imm_s;

  assign fd_opcode_s = fd_instr_r[W-1 -: OPW];
  assign fd_src_s    = fd_instr_r[W-OPW-1 -: RA];
  assign fd_dst_s    = fd_instr_r[W-OPW-RA-1 -: RA];
  assign fd_sham_s   = fd_instr_r[SHW-1:0];

  // Load-use hazard only matters while an instruction sits in HOLD.
  assign stall_s  = (state_r == HOLD) && ex_memread &&
                    ((ex_dst == fd_src_s) || (ex_dst == fd_dst_s));
  // Flush overrides the stall, so the front end is never blocked during it.
  assign fd_ready = flush | ~stall_s;
  assign accept_s = instr_valid & fd_ready & ~flush;

  // Operand reads bypass a same-cycle WB write to the indexed register.
  assign rsrc_s = (wb_we && (wb_addr == fd_src_s)) ? wb_data : regs_r[fd_src_s];
  assign rdst_s = (wb_we && (wb_addr == fd_dst_s)) ? wb_data : regs_r[fd_dst_s];

  // Next-state and issue control for the F/D FSM.
  always_comb begin
    state_n_s   = state_r;
    fd_load_s   = 1'b0;
    imm_cap_s   = 1'b0;
    pend_clr_s  = 1'b0;
    issue_s     = 1'b0;
    issue_imm_s = '0;
    if (flush) begin
      state_n_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_n_s = HOLD;
            fd_load_s = 1'b1;
          end else begin
            state_n_s = IDLE;
          end
        end
        HOLD: begin
          if (stall_s) begin
            state_n_s = HOLD;
          end else if (fd_opcode_s == IMM_OP) begin
            state_n_s = WAIT_IMM;
            imm_cap_s = accept_s;
          end else begin
            issue_s = 1'b1;
            if (accept_s) begin
              state_n_s = HOLD;
              fd_load_s = 1'b1;
            end else begin
              state_n_s = IDLE;
            end
          end
        end
        WAIT_IMM: begin
          if (imm_pend_r) begin
            issue_s     = 1'b1;
            issue_imm_s = imm_r;
            pend_clr_s  = 1'b1;
            if (accept_s) begin
              state_n_s = HOLD;
              fd_load_s = 1'b1;
            end else begin
              state_n_s = IDLE;
            end
          end else if (accept_s) begin
            issue_s     = 1'b1;
            issue_imm_s = instr_in;
            state_n_s   = IDLE;
          end else begin
            state_n_s = WAIT_IMM;
          end
        end
        default: begin
          state_n_s = IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // F/D holding register and parked immediate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fd_instr_r <= '0;
      imm_r      <= '0;
      imm_pend_r <= 1'b0;
    end else if (flush) begin
      fd_instr_r <= '0;
      imm_r      <= '0;
      imm_pend_r <= 1'b0;
    end else begin
      if (fd_load_s) begin
        fd_instr_r <= instr_in;
      end
      if (imm_cap_s) begin
        imm_r      <= instr_in;
        imm_pend_r <= 1'b1;
      end else if (pend_clr_s) begin
        imm_r      <= '0;
        imm_pend_r <= 1'b0;
      end
    end
  end

  // Register file write port; independent of stall and flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wb_we) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // D/E pipeline register: loads on issue, otherwise takes a zeroed bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_valid  <= 1'b0;
      de_opcode <= '0;
      de_src    <= '0;
      de_dst    <= '0;
      de_sham   <= '0;
      de_rsrc   <= '0;
      de_rdst   <= '0;
      de_imm    <= '0;
    end else if (flush || !issue_s) begin
      de_valid  <= 1'b0;
      de_opcode <= '0;
      de_src    <= '0;
      de_dst    <= '0;
      de_sham   <= '0;
      de_rsrc   <= '0;
      de_rdst   <= '0;
      de_imm    <= '0;
    end else begin
      de_valid  <= 1'b1;
      de_opcode <= fd_opcode_s;
      de_src    <= fd_src_s;
      de_dst    <= fd_dst_s;
      de_sham   <= fd_sham_s;
      de_rsrc   <= rsrc_s;
      de_rdst   <= rdst_s;
      de_imm    <= issue_imm_s;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run compared against a queue-based model of accepted words.
module tb_decode_stage;

  localparam int             W      = 16;
  localparam int             NREG   = 8;
  localparam int             OPW    = 6;
  localparam int             RA     = 3;
  localparam int             SHW    = 4;
  localparam logic [OPW-1:0] IMM_OP = 6'b011001;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  instr_in;
  logic          instr_valid;
  logic          fd_ready;
  logic          flush;
  logic          wb_we;
  logic [RA-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          ex_memread;
  logic [RA-1:0] ex_dst;
  logic          de_valid;
  logic [OPW-1:0] de_opcode;
  logic [RA-1:0] de_src;
  logic [RA-1:0] de_dst;
  logic [SHW-1:0] de_sham;
  logic [W-1:0]  de_rsrc;
  logic [W-1:0]  de_rdst;
  logic [W-1:0]  de_imm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .fd_ready(fd_ready), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_memread(ex_memread), .ex_dst(ex_dst),
    .de_valid(de_valid), .de_opcode(de_opcode), .de_src(de_src),
    .de_dst(de_dst), .de_sham(de_sham), .de_rsrc(de_rsrc),
    .de_rdst(de_rdst), .de_imm(de_imm)
  );

  logic [64:0] obs;
  assign obs = {de_valid, de_opcode, de_src, de_dst, de_sham, de_rsrc, de_rdst, de_imm};

  function automatic logic [OPW-1:0] f_op(input logic [W-1:0] w);
    return w[W-1 -: OPW];
  endfunction
  function automatic logic [RA-1:0] f_src(input logic [W-1:0] w);
    return w[W-OPW-1 -: RA];
  endfunction
  function automatic logic [RA-1:0] f_dst(input logic [W-1:0] w);
    return w[W-OPW-RA-1 -: RA];
  endfunction
  function automatic logic [SHW-1:0] f_sh(input logic [W-1:0] w);
    return w[SHW-1:0];
  endfunction

  // ---------------- reference model ----------------
  // m_q holds accepted words not yet issued (head instruction, then its
  // immediate if one arrived early); m_phase=1 once an IMM_OP head has
  // spent its first edge in F/D.
  logic [W-1:0] m_regs [NREG];
  logic [W-1:0] m_q[$];
  int           m_phase;
  logic [64:0]  e_bundle;

  task automatic m_reset();
    m_q.delete();
    m_phase  = 0;
    e_bundle = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
  endtask

  function automatic logic m_stall();
    if (m_q.size() == 0 || m_phase != 0) return 1'b0;
    return ex_memread && ((ex_dst == f_src(m_q[0])) || (ex_dst == f_dst(m_q[0])));
  endfunction

  function automatic logic m_ready();
    return flush || !m_stall();
  endfunction

  task automatic m_issue(input logic [W-1:0] w, input logic [W-1:0] imm);
    logic [W-1:0] rs;
    logic [W-1:0] rd;
    rs = (wb_we && wb_addr == f_src(w)) ? wb_data : m_regs[f_src(w)];
    rd = (wb_we && wb_addr == f_dst(w)) ? wb_data : m_regs[f_dst(w)];
    e_bundle = {1'b1, f_op(w), f_src(w), f_dst(w), f_sh(w), rs, rd, imm};
  endtask

  task automatic m_edge();
    logic acc;
    logic [W-1:0] head;
    acc = instr_valid && m_ready() && !flush;
    e_bundle = '0;
    if (flush) begin
      m_q.delete();
      m_phase = 0;
    end else if (m_stall()) begin
      m_phase = 0;
    end else if (m_q.size() == 0) begin
      if (acc) m_q.push_back(instr_in);
    end else if (f_op(m_q[0]) != IMM_OP) begin
      m_issue(m_q[0], 16'h0000);
      m_q.delete();
      if (acc) m_q.push_back(instr_in);
    end else if (m_phase == 0) begin
      m_phase = 1;
      if (acc) m_q.push_back(instr_in);
    end else if (m_q.size() == 2) begin
      m_issue(m_q[0], m_q[1]);
      m_q.delete();
      m_phase = 0;
      if (acc) m_q.push_back(instr_in);
    end else if (acc) begin
      head = m_q[0];
      m_issue(head, instr_in);
      m_q.delete();
      m_phase = 0;
    end
    if (wb_we) m_regs[wb_addr] = wb_data;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input logic [W-1:0] w, input logic fl,
                        input logic we, input logic [RA-1:0] wa, input logic [W-1:0] wd,
                        input logic mr, input logic [RA-1:0] ed);
    instr_valid = v; instr_in = w; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    ex_memread = mr; ex_dst = ed;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    rst = 1'b1;
    #3;
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if (obs !== 65'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", obs); end
    n_cmp++;
    if (fd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", fd_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h00AB, 1'b0, 3'd0); tick();
    set_in(1'b1, {6'b000101, 3'd3, 3'd1, 4'd2}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (de_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency: got %b want 0", de_valid); end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (obs !== {1'b1, 6'b000101, 3'd3, 3'd1, 4'd2, 16'h00AB, 16'h0000, 16'h0000}) begin
      n_bad++; $display("FAIL basic_issue: got %h want %h", obs,
        {1'b1, 6'b000101, 3'd3, 3'd1, 4'd2, 16'h00AB, 16'h0000, 16'h0000});
    end
  endtask

  task automatic test_imm();
    do_reset();
    set_in(1'b1, {IMM_OP, 3'd1, 3'd2, 4'd0}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b1, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (de_valid !== 1'b0) begin n_bad++; $display("FAIL imm_gap: got %b want 0", de_valid); end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (obs !== {1'b1, IMM_OP, 3'd1, 3'd2, 4'd0, 16'h0000, 16'h0000, 16'h1234}) begin
      n_bad++; $display("FAIL imm_issue: got %h want %h", obs,
        {1'b1, IMM_OP, 3'd1, 3'd2, 4'd0, 16'h0000, 16'h0000, 16'h1234});
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_in(1'b1, {6'b000101, 3'd4, 3'd1, 4'd0}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b1, 16'hFFFF, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4);
    #1;
    n_cmp++;
    if (fd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b want 0", fd_ready); end
    tick();
    n_cmp++;
    if (obs !== 65'd0) begin n_bad++; $display("FAIL stall_bubble: got %h want 0", obs); end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    #1;
    n_cmp++;
    if (fd_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b want 1", fd_ready); end
    tick();
    n_cmp++;
    if (obs !== {1'b1, 6'b000101, 3'd4, 3'd1, 4'd0, 48'h0}) begin
      n_bad++; $display("FAIL stall_issue: got %h want %h", obs, {1'b1, 6'b000101, 3'd4, 3'd1, 4'd0, 48'h0});
    end
    tick();
    n_cmp++;
    if (de_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drop: got %b want 0", de_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    set_in(1'b1, {IMM_OP, 3'd1, 3'd2, 4'd0}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b1, 16'h5555, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1);
    #1;
    n_cmp++;
    if (fd_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", fd_ready); end
    tick();
    n_cmp++;
    if (obs !== 65'd0) begin n_bad++; $display("FAIL flush_bubble: got %h want 0", obs); end
    set_in(1'b1, 16'h1234, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (de_valid !== 1'b0) begin n_bad++; $display("FAIL flush_noimm: got %b want 0", de_valid); end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (obs !== {1'b1, 6'b000100, 3'd4, 3'd3, 4'd4, 48'h0}) begin
      n_bad++; $display("FAIL flush_redecode: got %h want %h", obs, {1'b1, 6'b000100, 3'd4, 3'd3, 4'd4, 48'h0});
    end
  endtask

  task automatic test_write_through();
    do_reset();
    set_in(1'b1, {6'b000101, 3'd5, 3'd0, 4'd0}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0); tick();
    n_cmp++;
    if (obs !== {1'b1, 6'b000101, 3'd5, 3'd0, 4'd0, 16'hBEEF, 16'h0000, 16'h0000}) begin
      n_bad++; $display("FAIL wt_rsrc: got %h want %h", obs,
        {1'b1, 6'b000101, 3'd5, 3'd0, 4'd0, 16'hBEEF, 16'h0000, 16'h0000});
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    set_in(1'b1, {6'b000101, 3'd1, 3'd2, 4'd3}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b1, {6'b000110, 3'd3, 3'd4, 4'd5}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (de_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre: got %b want 1", de_valid); end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if (obs !== 65'd0) begin n_bad++; $display("FAIL arst_drop: got %h want 0", obs); end
    rst = 1'b0;
    #1;
    tick();
    n_cmp++;
    if (de_valid !== 1'b0) begin n_bad++; $display("FAIL arst_discard: got %b want 0", de_valid); end
  endtask

  task automatic test_rst_wait();
    do_reset();
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h7777, 1'b0, 3'd0); tick();
    set_in(1'b1, {IMM_OP, 3'd2, 3'd2, 4'd0}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    set_in(1'b1, {6'b000100, 3'd2, 3'd3, 4'd4}, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0); tick();
    n_cmp++;
    if (obs !== {1'b1, 6'b000100, 3'd2, 3'd3, 4'd4, 48'h0}) begin
      n_bad++; $display("FAIL rst_wait_decode: got %h want %h", obs, {1'b1, 6'b000100, 3'd2, 3'd3, 4'd4, 48'h0});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    do_reset();
    m_reset();
    for (int c = 0; c < 800; c++) begin
      w = W'($urandom);
      if ($urandom_range(0, 3) == 0) w[W-1 -: OPW] = IMM_OP;
      set_in(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 19) == 0),
             1'(($urandom)), RA'($urandom), W'($urandom),
             ($urandom_range(0, 4) == 0), RA'($urandom));
      #1;
      n_cmp++;
      if (fd_ready !== m_ready()) begin
        n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, fd_ready, m_ready());
      end
      m_edge();
      tick();
      n_cmp++;
      if (obs !== e_bundle) begin
        n_bad++; $display("FAIL rand_de[%0d]: got %h want %h", c, obs, e_bundle);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_basic();
    test_imm();
    test_stall();
    test_flush();
    test_write_through();
    test_async_rst();
    test_rst_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
